cnn_layer_sequencer: RTL and testbench

Frame-level controller for the CNN accelerator. It accepts one input feature map as a raster-order pixel stream and writes it into the CNN input port with generated addresses. It then starts each layer (conv2d L1, conv2d L2, dense) in order, waits for each layer's done pulse under a watchdog timeout, and signals frame completion. It sits between the host/stream source and the CNN datapath's input and layer-control ports.

---
 rtl/cnn_layer_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Purpose: frame controller; streams one raster-order feature map into the CNN input port, then starts each layer and waits for its done pulse.
// Latency: one cycle from upstream handshake to CNN write; layer start one cycle after last write or previous layer's done.
// Backpressure: pixel_ready_o drops while the output register holds an unaccepted pixel; one pixel per cycle when cnn_input_ready_i stays high.
//
// Ports:
//   clk_i, rst_i (sync, active-high)  start_i / abort_i        frame control
//   pixel_valid_i/_data_i/_ready_o    upstream raster pixel stream (valid-ready)
//   cnn_input_valid_o/_data_o/_addr_o/_ready_i  addressed pixel writes into the CNN
//   layer_start_o / layer_done_i      one-hot start pulse, per-layer done pulse
//   cur_layer_o, busy_o, frame_done_o, error_o, err_layer_o  status
module cnn_layer_sequencer #(
  parameter int F_IN_W1                = 29,
  parameter int F_IN_H1                = 29,
  parameter int FEATURE_MAP_RESOLUTION = 8,
  parameter int FEATURE_MAP_ADDRWIDE   = 10,
  parameter int NUM_LAYERS             = 3,
  parameter int TIMEOUT_CYCLES         = 65535,
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic                              pixel_valid_i,
  input  logic [FEATURE_MAP_RESOLUTION-1:0] pixel_data_i,
  output logic                              pixel_ready_o,
  output logic                              cnn_input_valid_o,
  output logic [FEATURE_MAP_RESOLUTION-1:0] cnn_input_data_o,
  output logic [FEATURE_MAP_ADDRWIDE-1:0]   cnn_input_addr_o,
  input  logic                              cnn_input_ready_i,
  output logic [NUM_LAYERS-1:0]             layer_start_o,
  input  logic [NUM_LAYERS-1:0]             layer_done_i,
  output logic [LAYER_W-1:0]                cur_layer_o,
  output logic                              busy_o,
  output logic                              frame_done_o,
  output logic                              error_o,
  output logic [LAYER_W-1:0]                err_layer_o
);

  localparam int N     = F_IN_W1 * F_IN_H1;
  localparam int CNT_W = $clog2(N + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   acc_cnt;   // pixels accepted from upstream this frame
  logic [WD_W-1:0]    wd_cnt;    // cycles spent in WAIT for the current layer
  logic               up_hs;
  logic               cnn_hs;
  logic               cur_done;
  logic               last_layer;
  logic [LAYER_W-1:0] next_layer;

  // Accept a new pixel only while the frame is incomplete and the output
  // register is empty or being drained this cycle.
  assign pixel_ready_o = (state == S_LOAD) && (acc_cnt < CNT_W'(N)) &&
                         (!cnn_input_valid_o || cnn_input_ready_i);
  assign up_hs      = pixel_valid_i && pixel_ready_o;
  assign cnn_hs     = cnn_input_valid_o && cnn_input_ready_i;
  assign cur_done   = layer_done_i[cur_layer_o];
  assign last_layer = (cur_layer_o == LAYER_W'(NUM_LAYERS - 1));
  assign next_layer = cur_layer_o + LAYER_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= S_IDLE;
      acc_cnt           <= '0;
      wd_cnt            <= '0;
      cnn_input_valid_o <= 1'b0;
      cnn_input_data_o  <= '0;
      cnn_input_addr_o  <= '0;
      layer_start_o     <= '0;
      cur_layer_o       <= '0;
      busy_o            <= 1'b0;
      frame_done_o      <= 1'b0;
      error_o           <= 1'b0;
      err_layer_o       <= '0;
    end else begin
      // Start and done are single-cycle pulses unless re-armed below.
      layer_start_o <= '0;
      frame_done_o  <= 1'b0;
      if (abort_i) begin
        state             <= S_IDLE;
        busy_o            <= 1'b0;
        cnn_input_valid_o <= 1'b0;
        error_o           <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            acc_cnt          <= '0;
            cnn_input_addr_o <= '0;
            cur_layer_o      <= '0;
            if (start_i) begin
              state  <= S_LOAD;
              busy_o <= 1'b1;
            end
          end
          S_LOAD: begin
            if (up_hs) begin
              cnn_input_data_o  <= pixel_data_i;
              cnn_input_addr_o  <= FEATURE_MAP_ADDRWIDE'(acc_cnt);
              cnn_input_valid_o <= 1'b1;
              acc_cnt           <= acc_cnt + CNT_W'(1);
            end else if (cnn_hs) begin
              cnn_input_valid_o <= 1'b0;
            end
            // Once all N pixels are accepted, the register holds the last
            // one; its drain completes the load phase.
            if (cnn_hs && (acc_cnt == CNT_W'(N))) begin
              state         <= S_START;
              cur_layer_o   <= '0;
              layer_start_o <= NUM_LAYERS'(1);
            end
          end
          S_START: begin
            state  <= S_WAIT;
            wd_cnt <= '0;
          end
          S_WAIT: begin
            // A done arriving on the final watchdog cycle still wins.
            if (cur_done) begin
              if (last_layer) begin
                state        <= S_DONE;
                frame_done_o <= 1'b1;
              end else begin
                state         <= S_START;
                cur_layer_o   <= next_layer;
                layer_start_o <= NUM_LAYERS'(1) << next_layer;
              end
            end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
              state       <= S_ERROR;
              error_o     <= 1'b1;
              err_layer_o <= cur_layer_o;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
          S_ERROR: begin
            state <= S_ERROR;
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Purpose: directed/randomized bench for cnn_layer_sequencer with a queue scoreboard for pixel writes.
// Latency: checks cycle-exact start/done/timeout timing against the sequencing rules.
// Backpressure: exercises alternating cnn_input_ready_i and random upstream valid gaps.
module tb_cnn_layer_sequencer;

  localparam int W   = 29;
  localparam int H   = 29;
  localparam int N   = W * H;
  localparam int RES = 8;
  localparam int AW  = 10;
  localparam int NL  = 3;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic           abort_i;
  logic           pixel_valid_i;
  logic [RES-1:0] pixel_data_i;
  logic           pixel_ready_o;
  logic           cnn_input_valid_o;
  logic [RES-1:0] cnn_input_data_o;
  logic [AW-1:0]  cnn_input_addr_o;
  logic           cnn_input_ready_i;
  logic [NL-1:0]  layer_start_o;
  logic [NL-1:0]  layer_done_i;
  logic [1:0]     cur_layer_o;
  logic           busy_o;
  logic           frame_done_o;
  logic           error_o;
  logic [1:0]     err_layer_o;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .F_IN_W1(W), .F_IN_H1(H), .FEATURE_MAP_RESOLUTION(RES),
    .FEATURE_MAP_ADDRWIDE(AW), .NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .pixel_valid_i(pixel_valid_i), .pixel_data_i(pixel_data_i),
    .pixel_ready_o(pixel_ready_o), .cnn_input_valid_o(cnn_input_valid_o),
    .cnn_input_data_o(cnn_input_data_o), .cnn_input_addr_o(cnn_input_addr_o),
    .cnn_input_ready_i(cnn_input_ready_i), .layer_start_o(layer_start_o),
    .layer_done_i(layer_done_i), .cur_layer_o(cur_layer_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .error_o(error_o), .err_layer_o(err_layer_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: pixels accepted upstream must reach the CNN in order,
  // with address equal to their position in the frame.
  logic [RES-1:0] exp_q[$];
  int             wr_cnt;
  int             pop_idx;
  int             last_addr;
  int             start_cnt[NL];
  int             fd_cnt;
  bit             stall_prev;
  logic [RES-1:0] prev_dat;
  logic [AW-1:0]  prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_i || abort_i || (start_i && !busy_o)) begin
      exp_q.delete();
      wr_cnt = 0; pop_idx = 0; last_addr = -1; fd_cnt = 0; stall_prev = 0;
      for (int l = 0; l < NL; l++) start_cnt[l] = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_data", cnn_input_data_o, prev_dat);
        chk("stall_addr", cnn_input_addr_o, prev_addr);
      end
      if (cnn_input_valid_o && cnn_input_ready_i) begin
        chk("write_has_pixel", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("write_data", cnn_input_data_o, exp_q.pop_front());
          chk("write_addr", cnn_input_addr_o, pop_idx);
        end
        last_addr = cnn_input_addr_o;
        pop_idx++;
        wr_cnt++;
      end
      if (pixel_valid_i && pixel_ready_o) exp_q.push_back(pixel_data_i);
      stall_prev = cnn_input_valid_o && !cnn_input_ready_i;
      prev_dat   = cnn_input_data_o;
      prev_addr  = cnn_input_addr_o;
      for (int l = 0; l < NL; l++) if (layer_start_o[l]) start_cnt[l]++;
      if (frame_done_o) fd_cnt++;
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_pixel_ready"}, pixel_ready_o, 0);
    chk({tag, "_cnn_valid"}, cnn_input_valid_o, 0);
    chk({tag, "_cnn_data"}, cnn_input_data_o, 0);
    chk({tag, "_cnn_addr"}, cnn_input_addr_o, 0);
    chk({tag, "_layer_start"}, layer_start_o, 0);
    chk({tag, "_cur_layer"}, cur_layer_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_frame_done"}, frame_done_o, 0);
    chk({tag, "_error"}, error_o, 0);
    chk({tag, "_err_layer"}, err_layer_o, 0);
  endtask

  // Streams a frame (or its first abort_at pixels, then aborts).
  // Returns in the cycle after the last CNN write, i.e. layer 0 START.
  task automatic load_frame(input bit bp, input int abort_at);
    bit             have;
    bit             done;
    logic [RES-1:0] cur;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("load_busy", busy_o, 1);
    chk("load_first_ready", pixel_ready_o, 1);
    have = 0; done = 0; cur = '0;
    for (int c = 0; c < 6000 && !done; c++) begin
      cnn_input_ready_i = bp ? (c % 2 == 0) : 1'b1;
      if (!have) begin cur = RES'($urandom); have = 1; end
      pixel_valid_i = bp ? ($urandom_range(3, 0) != 0) : 1'b1;
      pixel_data_i  = cur;
      #1;
      if (pixel_valid_i && pixel_ready_o) have = 0;
      @(negedge clk);
      #1;
      if (wr_cnt == N || (abort_at > 0 && wr_cnt >= abort_at)) done = 1;
      else begin @(posedge clk); #1; end
    end
    chk("load_within_budget", done, 1);
    cyc();
    if (abort_at > 0) begin
      abort_i = 1'b1; pixel_valid_i = 1'b0; cnn_input_ready_i = 1'b0;
      cyc();
      abort_i = 1'b0;
      chk("abort_busy", busy_o, 0);
      chk("abort_cnn_valid", cnn_input_valid_o, 0);
      chk("abort_pixel_ready", pixel_ready_o, 0);
      cnn_input_ready_i = 1'b1;
    end else begin
      pixel_valid_i = 1'b0;
      cnn_input_ready_i = 1'b1;
    end
  endtask

  // Sequences all layers from layer 0 START. hang: layer that never
  // completes (timeout, or reset when use_rst). edge_l: layer whose done
  // arrives on the last cycle before the watchdog would fire.
  task automatic run_layers(input bit noise, input int hang, input bit use_rst, input int edge_l);
    for (int l = 0; l < NL; l++) begin
      int d;
      chk("start_pulse", layer_start_o, 32'(1) << l);
      chk("start_cur_layer", cur_layer_o, l);
      chk("start_busy", busy_o, 1);
      if (noise) layer_done_i = NL'(1 << l);
      cyc();
      layer_done_i = '0;
      if (l == hang) begin
        if (use_rst) begin
          repeat (5) cyc();
          rst_i = 1'b1;
          cyc();
          rst_i = 1'b0;
          return;
        end
        for (int k = 0; k < TO; k++) begin
          chk("timeout_not_yet", error_o, 0);
          if (noise) layer_done_i = NL'($urandom) & ~NL'(1 << l);
          cyc();
        end
        layer_done_i = '0;
        chk("timeout_error", error_o, 1);
        chk("timeout_err_layer", err_layer_o, l);
        chk("timeout_busy", busy_o, 1);
        chk("timeout_no_start", layer_start_o, 0);
        return;
      end
      d = (l == edge_l) ? TO - 1 : int'($urandom_range(TO - 2, 0));
      for (int k = 0; k < d; k++) begin
        chk("wait_no_start", layer_start_o, 0);
        chk("wait_no_frame_done", frame_done_o, 0);
        if (noise) begin
          start_i = 1'b1;
          layer_done_i = NL'($urandom) & ~NL'(1 << l);
        end
        cyc();
      end
      start_i = 1'b0;
      layer_done_i = NL'(1 << l);
      cyc();
      layer_done_i = '0;
      chk("after_done_no_error", error_o, 0);
      if (l == NL - 1) begin
        chk("frame_done_pulse", frame_done_o, 1);
        chk("frame_done_busy", busy_o, 1);
        cyc();
        chk("frame_done_cleared", frame_done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_no_start", layer_start_o, 0);
      end
    end
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_writes"}, wr_cnt, N);
    chk({tag, "_last_addr"}, last_addr, N - 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    for (int l = 0; l < NL; l++) chk({tag, "_start_count"}, start_cnt[l], 1);
    chk({tag, "_frame_done_count"}, fd_cnt, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    pixel_valid_i = 1'b0; pixel_data_i = '0;
    cnn_input_ready_i = 1'b1; layer_done_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("rst_hold");
    rst_i = 1'b0;
    cyc();
    chk_rst("rst_idle");

    // Full frame, no backpressure.
    load_frame(1'b0, 0);
    run_layers(1'b0, -1, 1'b0, -1);
    end_checks("frame_plain");

    // Backpressure plus ignored start/done events; layer 1 done on the
    // final watchdog cycle.
    load_frame(1'b1, 0);
    run_layers(1'b1, -1, 1'b0, 1);
    end_checks("frame_bp");

    // Timeout on layer 1, stays in ERROR despite start, abort clears.
    load_frame(1'b0, 0);
    run_layers(1'b1, 1, 1'b0, -1);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("error_sticky", error_o, 1);
    chk("error_busy", busy_o, 1);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("abort_err_clear", error_o, 0);
    chk("abort_err_idle", busy_o, 0);

    // Abort in LOAD after 100 pixels; next frame restarts at address 0.
    load_frame(1'b0, 100);
    load_frame(1'b0, 0);
    run_layers(1'b0, -1, 1'b0, -1);
    end_checks("frame_after_abort");

    // Reset mid-WAIT of layer 1, then a normal frame.
    load_frame(1'b0, 0);
    run_layers(1'b0, 1, 1'b1, -1);
    chk_rst("rst_mid_wait");
    load_frame(1'b1, 0);
    run_layers(1'b0, -1, 1'b0, -1);
    end_checks("frame_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
